// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered 8-bit UART transmitter.
// A byte FIFO feeds a baud-timed serializer that drains queued bytes
// back-to-back onto uart_txd (start bit, 8 data bits LSB first, optional
// even parity, STOP_BITS stop bits). The line output is registered.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// after the data bits. Without it no parity state or parity logic exists.
//
// Write handshake: a byte on wr_data is accepted on a rising clk edge when
// wr_en and wr_ready are both high. wr_ready is low only while the FIFO is
// full; wr_en asserted while full drops the byte and sets the sticky
// overflow flag, regardless of a pop happening in the same cycle.
module uart_tx_buffered #(
    parameter int CLK_HZ     = 27_000_000,
    parameter int BIT_RATE   = 9600,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    output logic                        wr_ready,
    input  logic                        tx_en,
    output logic                        uart_txd,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    // Clocks per bit period, truncated.
    localparam int CPB       = CLK_HZ / BIT_RATE;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = AW + 1;
    localparam int STOP_CLKS = STOP_BITS * CPB;
    // The timing counter must reach the longest period, i.e. the stop phase.
    localparam int TW        = $clog2(STOP_CLKS + 1);

    localparam logic [TW-1:0] BIT_LAST  = TW'(CPB - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_CLKS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    // Serializer states; PARITY exists only when the parity option is built.
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } tx_state_e;
`endif

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    // Full is judged on the registered count, so a same-cycle pop never
    // makes room for a push.
    assign push  = wr_en & ~full;
    assign head  = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Serializer registers
    // ------------------------------------------------------------------
    tx_state_e     state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    // Byte storage: written on accepted pushes only, needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO next-state: pointers wrap naturally (depth is a power of two).
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (wr_en & full);
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state register with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Serializer next-state and line value. txd_d is a function of the
    // current state, so the registered line lags the state by one clock:
    // the pop happens at N+1 and the start bit appears on the line at N+2.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        txd_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (tx_en && !empty) begin
                    pop     = 1'b1;
                    shift_d = head;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                txd_d = 1'b0;
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_DATA: begin
                txd_d = shift_q[0];
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                txd_d = parity_q;
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
`endif
            S_STOP: begin
                txd_d = 1'b1;
                if (cnt_q == STOP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: begin
                txd_d   = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Serializer state register; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign wr_ready   = ~full;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign uart_txd   = txd_q;
    assign tx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: self-checking bench for uart_tx_buffered.
// CPB = 10, FIFO_DEPTH = 16, STOP_BITS = 1. Honours UART_TX_PARITY_EN.
module tb_uart_tx_buffered;

    localparam int CPB   = 10;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam logic EXP_BIT9_41 = 1'b0;
`else
    localparam int NBITS = 10;
    localparam logic EXP_BIT9_41 = 1'b1;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk     = 1'b0;
    logic       resetn  = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_en   = 1'b0;
    logic       wr_ready;
    logic       uart_txd;
    logic       tx_busy;
    logic [4:0] fifo_count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rx     = 0;

    uart_tx_buffered #(
        .CLK_HZ    (1000),
        .BIT_RATE  (100),
        .FIFO_DEPTH(DEPTH),
        .STOP_BITS (1)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .tx_en     (tx_en),
        .uart_txd  (uart_txd),
        .tx_busy   (tx_busy),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of stored bytes plus the age (clocks since
    // the pop) of the frame on the line. The line value is the frame bit
    // at the previous age because the output is registered.
    // ------------------------------------------------------------------
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    bit         m_busy = 1'b0;
    int         m_age  = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_txd  = 1'b1;
    logic       m_ovf  = 1'b0;

    function automatic logic wave(input logic [7:0] b, input int age);
        int bp;
        bp = age / CPB;
        if (bp == 0) return 1'b0;
        if (bp <= 8) return b[bp-1];
`ifdef UART_TX_PARITY_EN
        if (bp == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    initial begin
        bit do_pop;
        bit was_full;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_q.delete();
                exp_q.delete();
                m_busy = 1'b0;
                m_age  = 0;
                m_txd  = 1'b1;
                m_ovf  = 1'b0;
            end else begin
                m_txd    = m_busy ? wave(m_byte, m_age) : 1'b1;
                do_pop   = !m_busy && tx_en && (m_q.size() != 0);
                was_full = (m_q.size() == DEPTH);
                if (wr_en && was_full) m_ovf = 1'b1;
                if (do_pop) begin
                    m_byte = m_q.pop_front();
                    m_busy = 1'b1;
                    m_age  = 0;
                end else if (m_busy) begin
                    if (m_age == FRAME - 1) m_busy = 1'b0;
                    else m_age++;
                end
                if (wr_en && !was_full) begin
                    m_q.push_back(wr_data);
                    exp_q.push_back(wr_data);
                end
            end
        end
    end

    // Cycle-by-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn === 1'b1) begin
                check("txd", uart_txd, m_txd);
                check("busy", tx_busy, m_busy);
                check("count", fifo_count, m_q.size());
                check("wr_ready", wr_ready, m_q.size() < DEPTH);
                check("overflow", overflow, m_ovf);
            end
        end
    end

    // Serial decoder: samples mid-bit and scores bytes against exp_q.
    initial begin
        bit         on;
        int         t;
        int         k;
        logic [7:0] acc;
        logic [7:0] e;
        on = 1'b0;
        t  = 0;
        acc = 8'h00;
        forever begin
            @(negedge clk or negedge resetn);
            if (!resetn) begin
                on = 1'b0;
            end else if (!on) begin
                if (uart_txd === 1'b0) begin
                    on  = 1'b1;
                    t   = 0;
                    acc = 8'h00;
                end
            end else begin
                t++;
                if (t % CPB == CPB / 2) begin
                    k = t / CPB - 1;
                    if (k < 8) begin
                        acc[k] = uart_txd;
`ifdef UART_TX_PARITY_EN
                    end else if (k == 8) begin
                        check("rx_parity", uart_txd, ^acc);
`endif
                    end else begin
                        check("rx_stop", uart_txd, 1'b1);
                        if (exp_q.size() == 0) begin
                            check("rx_unexpected", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("rx_byte", acc, e);
                        end
                        n_rx++;
                        on = 1'b0;
                    end
                end
            end
        end
    end

    // Driver tasks: called at posedge+1, return at posedge+1.
    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic wv[0:499];
    logic bz[0:499];

    task automatic sample(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wv[i] = uart_txd;
            bz[i] = tx_busy;
        end
    endtask

    task automatic report();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        n_fail++;
        report();
        $finish;
    end

    // Main sequence
    initial begin
        int busy_n;
        int rise[$];
        int n0;
        int c;
        int burst;
        bit drained;

        // Reset state
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", uart_txd, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", wr_ready, 1'b1);
        check("rst_ovf", overflow, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        tx_en = 1'b1;
        idle(2);

        // 0x41: index k+1 is the state after edge N+k
        fork
            push(8'h41);
            sample(FRAME + 20);
        join
        @(posedge clk);
        #1;
        busy_n = 0;
        for (int i = 0; i < FRAME + 20; i++) busy_n += int'(bz[i]);
        check("t1_idle_before", wv[2], 1'b1);
        check("t1_start_first", wv[3], 1'b0);
        check("t1_start_last", wv[12], 1'b0);
        check("t1_bit0", wv[13], 1'b1);
        check("t1_bit1", wv[23], 1'b0);
        check("t1_bit6", wv[73], 1'b1);
        check("t1_bit7", wv[83], 1'b0);
        check("t1_bit9", wv[93], EXP_BIT9_41);
        check("t1_busy_pre", bz[1], 1'b0);
        check("t1_busy_rise", bz[2], 1'b1);
        check("t1_busy_last", bz[FRAME + 1], 1'b1);
        check("t1_busy_fall", bz[FRAME + 2], 1'b0);
        check("t1_busy_len", busy_n, FRAME);
`ifdef UART_TX_PARITY_EN
        fork
            push(8'h01);
            sample(FRAME + 20);
        join
        @(posedge clk);
        #1;
        check("t1_parity_01", wv[93], 1'b1);
`endif

        // Three consecutive pushes: start edges FRAME+1 apart
        fork
            begin
                push(8'h55);
                push(8'hAA);
                push(8'h0F);
            end
            sample(3 * (FRAME + 1) + 20);
        join
        @(posedge clk);
        #1;
        for (int i = 1; i < 3 * (FRAME + 1) + 20; i++) begin
            if (bz[i] && !bz[i-1]) rise.push_back(i);
        end
        check("t2_frames", rise.size(), 3);
        if (rise.size() == 3) begin
            check("t2_gap01", rise[1] - rise[0], FRAME + 1);
            check("t2_gap12", rise[2] - rise[1], FRAME + 1);
            check("t2_start0", wv[rise[0] + 1], 1'b0);
            check("t2_start2", wv[rise[2] + 1], 1'b0);
            check("t2_pre2", wv[rise[2]], 1'b1);
        end
        check("t2_count_end", fifo_count, 0);

        // Fill with tx_en low, overflow on the 17th, then drain in order
        tx_en = 1'b0;
        idle(2);
        for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom));
        idle(1);
        check("t3_count", fifo_count, DEPTH);
        check("t3_ready", wr_ready, 1'b0);
        check("t3_ovf", overflow, 1'b1);
        n0 = n_rx;
        tx_en = 1'b1;
        idle(DEPTH * (FRAME + 1) + 20);
        check("t3_sent", n_rx - n0, DEPTH);
        check("t3_left", exp_q.size(), 0);

        // Reset in the middle of the data bits of 0xF0
        push(8'hF0);
        idle(35);
        #2;
        resetn = 1'b0;
        #1;
        check("t4_txd", uart_txd, 1'b1);
        check("t4_busy", tx_busy, 1'b0);
        check("t4_count", fifo_count, 0);
        check("t4_ovf", overflow, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        idle(30);
        check("t4_no_frame", tx_busy, 1'b0);
        check("t4_line_high", uart_txd, 1'b1);

        // Drop tx_en during bit 3 with two bytes queued
        push(8'h3C);
        push(8'hC3);
        push(8'h99);
        idle(42);
        tx_en = 1'b0;
        idle(FRAME);
        check("t5_count", fifo_count, 2);
        check("t5_txd", uart_txd, 1'b1);
        check("t5_busy", tx_busy, 1'b0);
        tx_en = 1'b1;
        idle(2 * (FRAME + 1) + 20);

        // Randomized traffic with occasional bursts and tx_en toggles
        burst = 0;
        for (c = 0; c < 2500; c++) begin
            wr_en   = ($urandom_range(0, 59) == 0) || (burst > 0);
            wr_data = 8'($urandom);
            if (burst > 0) burst--;
            if ($urandom_range(0, 499) == 0) burst = $urandom_range(5, 20);
            if ($urandom_range(0, 299) == 0) tx_en = ~tx_en;
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        tx_en = 1'b1;
        drained = 1'b0;
        for (c = 0; c < 20 * (FRAME + 1); c++) begin
            if (m_q.size() == 0 && !m_busy) begin
                drained = 1'b1;
                break;
            end
            idle(1);
        end
        check("rand_drained", drained, 1'b1);
        idle(20);
        check("rand_all_received", exp_q.size(), 0);

        report();
        $finish;
    end

endmodule
